// File: rtl/sprite_pkg.sv
// Shared widths and the per-channel register set for the sprite compositor.
package sprite_pkg;
    localparam int RGB_W = 12;
    localparam int HC_W  = 11;
    localparam int VC_W  = 10;
    localparam int XGA_W = 1024;

    typedef struct packed {
        logic [HC_W-1:0]  x;
        logic [VC_W-1:0]  y;
        logic [RGB_W-1:0] rgb;
        logic             anim;
    } spr_regs_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// Host-side write bus: sprite register writes and background profile writes.
interface sprite_compositor_if #(
    parameter int NUM_SPR = 4
);
    import sprite_pkg::*;
    localparam int SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [HC_W-1:0]  wr_x;
    logic [VC_W-1:0]  wr_y;
    logic [RGB_W-1:0] wr_rgb;
    logic             wr_anim;
    logic             prof_we;
    logic [9:0]       prof_addr;
    logic [VC_W-1:0]  prof_data;

    modport master (output wr_en, wr_sel, wr_x, wr_y, wr_rgb, wr_anim, prof_we, prof_addr, prof_data);
    modport slave  (input  wr_en, wr_sel, wr_x, wr_y, wr_rgb, wr_anim, prof_we, prof_addr, prof_data);
endinterface

// File: rtl/sprite_channel.sv
// One sprite channel: double-buffered registers, animation frame counter and
// a registered hit test against the incoming pixel position.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int SEL_W      = 2,
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 10,
    parameter int LOG_FRAMES = 2
) (
    input  logic                  vclock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  spr_regs_t             wr_regs,
    input  logic                  swap,
    input  logic                  step,
    input  logic [HC_W-1:0]       hcount,
    input  logic [VC_W-1:0]       vcount,
    output logic                  hit_reg,
    output logic [RGB_W-1:0]      rgb_reg,
    output logic [LOG_FRAMES-1:0] frame_reg
);
    localparam logic [SEL_W-1:0] MY_SEL = SEL_W'(IDX);

    spr_regs_t pend_reg;
    spr_regs_t act_reg;

    // One extra bit on the right/bottom bounds so boxes at the screen edge never wrap.
    logic [HC_W:0] x_end;
    logic [VC_W:0] y_end;
    logic          hit_next;

    assign x_end = {1'b0, act_reg.x} + (HC_W+1)'(SPR_W);
    assign y_end = {1'b0, act_reg.y} + (VC_W+1)'(SPR_H);

    assign hit_next = (act_reg.rgb != '0)
                    && (hcount >= act_reg.x) && ({1'b0, hcount} < x_end)
                    && (vcount >= act_reg.y) && ({1'b0, vcount} < y_end);

    always_ff @(posedge vclock) begin
        if (reset) begin
            pend_reg  <= '0;
            act_reg   <= '0;
            frame_reg <= '0;
            hit_reg   <= 1'b0;
            rgb_reg   <= '0;
        end else begin
            if (wr_en && wr_sel == MY_SEL) begin
                pend_reg <= wr_regs;
            end
            // A write on the swap cycle lands in pending after the copy reads the old value.
            if (swap) begin
                act_reg <= pend_reg;
            end
            if (step && act_reg.anim) begin
                frame_reg <= frame_reg + 1'b1;
            end
            hit_reg <= hit_next;
            rgb_reg <= act_reg.rgb;
        end
    end
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: sprite channels over a sky/sea profile background,
// with syncs and blank delayed to line up with p_rgb.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int               NUM_SPR    = 4,
    parameter int               SPR_W      = 20,
    parameter int               SPR_H      = 10,
    parameter int               LOG_FRAMES = 2,
    parameter int               FRAME_DIV  = 8,
    parameter logic [RGB_W-1:0] SKY_RGB    = 12'h00F,
    parameter logic [RGB_W-1:0] SEA_RGB    = 12'h048
) (
    input  logic                            vclock,
    input  logic                            reset,
    input  logic [HC_W-1:0]                 hcount,
    input  logic [VC_W-1:0]                 vcount,
    input  logic                            hsync,
    input  logic                            vsync,
    input  logic                            blank,
    sprite_compositor_if.slave              bus,
    output logic [NUM_SPR*LOG_FRAMES-1:0]   cur_frame,
    output logic [RGB_W-1:0]                p_rgb,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            blank_out
);
    localparam int SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [VC_W-1:0]  prof_mem [XGA_W];
    logic [VC_W-1:0]  prof_rd_reg;

    logic [VC_W-1:0]  vcount_s1_reg;
    logic             hsync_s1_reg, vsync_s1_reg, blank_s1_reg;
    logic             hsync_s2_reg, vsync_s2_reg, blank_s2_reg;
    logic [RGB_W-1:0] p_rgb_reg;
    logic [DIV_W-1:0] div_reg;

    logic             vfall, step;
    spr_regs_t        wr_regs;
    logic             hit     [NUM_SPR];
    logic [RGB_W-1:0] spr_rgb [NUM_SPR];
    logic [RGB_W-1:0] bg_rgb, mux_rgb;

    // Read-first RAM: a same-address write is seen by the next read, not this one.
    always_ff @(posedge vclock) begin
        if (bus.prof_we) begin
            prof_mem[bus.prof_addr] <= bus.prof_data;
        end
        prof_rd_reg <= prof_mem[hcount[9:0]];
    end

    assign vfall   = vsync_s1_reg & ~vsync;
    assign step    = vfall && (div_reg == DIV_W'(FRAME_DIV - 1));
    assign wr_regs = '{x: bus.wr_x, y: bus.wr_y, rgb: bus.wr_rgb, anim: bus.wr_anim};

    generate
        for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_chan
            sprite_channel #(
                .IDX        (gi),
                .SEL_W      (SEL_W),
                .SPR_W      (SPR_W),
                .SPR_H      (SPR_H),
                .LOG_FRAMES (LOG_FRAMES)
            ) u_chan (
                .vclock    (vclock),
                .reset     (reset),
                .wr_en     (bus.wr_en),
                .wr_sel    (bus.wr_sel),
                .wr_regs   (wr_regs),
                .swap      (vfall),
                .step      (step),
                .hcount    (hcount),
                .vcount    (vcount),
                .hit_reg   (hit[gi]),
                .rgb_reg   (spr_rgb[gi]),
                .frame_reg (cur_frame[gi*LOG_FRAMES +: LOG_FRAMES])
            );
        end
    endgenerate

    // Walk from the lowest priority upward so the lowest hitting index wins.
    always_comb begin
        bg_rgb  = (vcount_s1_reg < prof_rd_reg) ? SKY_RGB : SEA_RGB;
        mux_rgb = bg_rgb;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                mux_rgb = spr_rgb[i];
            end
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            vcount_s1_reg <= '0;
            hsync_s1_reg  <= 1'b1;
            vsync_s1_reg  <= 1'b1;
            blank_s1_reg  <= 1'b1;
            hsync_s2_reg  <= 1'b1;
            vsync_s2_reg  <= 1'b1;
            blank_s2_reg  <= 1'b1;
            p_rgb_reg     <= '0;
            div_reg       <= '0;
        end else begin
            vcount_s1_reg <= vcount;
            hsync_s1_reg  <= hsync;
            vsync_s1_reg  <= vsync;
            blank_s1_reg  <= blank;
            hsync_s2_reg  <= hsync_s1_reg;
            vsync_s2_reg  <= vsync_s1_reg;
            blank_s2_reg  <= blank_s1_reg;
            p_rgb_reg     <= blank_s1_reg ? '0 : mux_rgb;
            if (vfall) begin
                div_reg <= step ? '0 : div_reg + 1'b1;
            end
        end
    end

    assign p_rgb     = p_rgb_reg;
    assign hsync_out = hsync_s2_reg;
    assign vsync_out = vsync_s2_reg;
    assign blank_out = blank_s2_reg;
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: pixel expectations queued at drive
// time and compared two clocks later; frame counters checked against a small model.
module tb_sprite_compositor;
    import sprite_pkg::*;

    logic             vclock;
    logic             reset;
    logic [HC_W-1:0]  hcount;
    logic [VC_W-1:0]  vcount;
    logic             hsync, vsync, blank;
    logic [7:0]       cur_frame;
    logic [RGB_W-1:0] p_rgb;
    logic             hsync_out, vsync_out, blank_out;

    sprite_compositor_if #(.NUM_SPR(4)) bus ();

    sprite_compositor dut (
        .vclock    (vclock),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .bus       (bus),
        .cur_frame (cur_frame),
        .p_rgb     (p_rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out)
    );

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    int cyc = 0;
    always @(posedge vclock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] exp;
        string       tag;
    } sb_t;
    sb_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Pixel result emerges two edges after the inputs are captured.
    always @(negedge vclock) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            check(e.tag, {20'd0, p_rgb}, {20'd0, e.exp});
        end
    end

    // Frame-counter model.
    logic [1:0] frm_m [4];
    bit         pend_anim [4];
    bit         act_anim  [4];
    int         div_m;

    task automatic pix(input int h, input int v, input bit b, input logic [11:0] exp, input string tag);
        @(negedge vclock);
        hcount = HC_W'(h);
        vcount = VC_W'(v);
        blank  = b;
        sb.push_back('{cyc + 2, exp, tag});
    endtask

    task automatic wr_spr(input int sel, input int x, input int y, input logic [11:0] rgb, input bit anim);
        @(negedge vclock);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 2'(sel);
        bus.wr_x    = HC_W'(x);
        bus.wr_y    = VC_W'(y);
        bus.wr_rgb  = rgb;
        bus.wr_anim = anim;
        @(negedge vclock);
        bus.wr_en = 1'b0;
        pend_anim[sel] = anim;
    endtask

    task automatic vfall(input bit do_wr, input int sel, input int x, input int y,
                         input logic [11:0] rgb, input bit anim);
        bit stp;
        @(negedge vclock);
        vsync = 1'b0;
        blank = 1'b1;
        if (do_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 2'(sel);
            bus.wr_x    = HC_W'(x);
            bus.wr_y    = VC_W'(y);
            bus.wr_rgb  = rgb;
            bus.wr_anim = anim;
        end
        @(negedge vclock);
        vsync     = 1'b1;
        bus.wr_en = 1'b0;
        @(negedge vclock);
        stp = (div_m == 7);
        for (int i = 0; i < 4; i++) begin
            if (stp && act_anim[i]) frm_m[i] = frm_m[i] + 2'd1;
            act_anim[i] = pend_anim[i];
        end
        div_m = stp ? 0 : div_m + 1;
        if (do_wr) pend_anim[sel] = anim;
        check("cur_frame", {24'd0, cur_frame}, {24'd0, frm_m[3], frm_m[2], frm_m[1], frm_m[0]});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge vclock);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            frm_m[i] = 2'd0; pend_anim[i] = 1'b0; act_anim[i] = 1'b0;
        end
        div_m = 0;
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        hcount = '0; vcount = '0;
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_x = '0; bus.wr_y = '0;
        bus.wr_rgb = '0; bus.wr_anim = 1'b0;
        bus.prof_we = 1'b0; bus.prof_addr = '0; bus.prof_data = '0;

        // 1. reset
        repeat (3) @(negedge vclock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge vclock);
            check("rst_p_rgb", {20'd0, p_rgb}, 32'd0);
            check("rst_vsync_out", {31'd0, vsync_out}, 32'd1);
            check("rst_cur_frame", {24'd0, cur_frame}, 32'd0);
        end
        check("rst_blank_out", {31'd0, blank_out}, 32'd1);

        // Profile: horizon at row 384 everywhere, 400 at column 300.
        for (int i = 0; i < 1024; i++) begin
            @(negedge vclock);
            bus.prof_we   = 1'b1;
            bus.prof_addr = 10'(i);
            bus.prof_data = (i == 300) ? 10'd400 : 10'd384;
        end
        @(negedge vclock);
        bus.prof_we = 1'b0;

        // 2. single sprite
        wr_spr(0, 100, 50, 12'hFFF, 1'b0);
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(100, 50, 1'b0, 12'hFFF, "s2_tl");
        pix(99,  50, 1'b0, 12'h00F, "s2_left");
        pix(120, 50, 1'b0, 12'h00F, "s2_right");
        pix(119, 59, 1'b0, 12'hFFF, "s2_br");
        pix(119, 60, 1'b0, 12'h00F, "s2_below");
        pix(100, 49, 1'b0, 12'h00F, "s2_above");

        // 3. priority
        wr_spr(0, 200, 200, 12'hFFF, 1'b0);
        wr_spr(1, 200, 200, 12'h0F0, 1'b0);
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(210, 205, 1'b0, 12'hFFF, "s3_ovl_ch0");
        pix(100, 50,  1'b0, 12'h00F, "s3_old_pos");
        pix(220, 209, 1'b0, 12'h00F, "s3_outside");
        wr_spr(0, 200, 200, 12'h000, 1'b0);
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(210, 205, 1'b0, 12'h0F0, "s3_ovl_ch1");

        // 4. double buffering
        wr_spr(2, 400, 300, 12'hF00, 1'b0);
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(405, 305, 1'b0, 12'hF00, "s4_at400");
        wr_spr(2, 500, 300, 12'hF00, 1'b0);
        pix(405, 305, 1'b0, 12'hF00, "s4_hold400");
        pix(505, 305, 1'b0, 12'h00F, "s4_not500");
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(405, 305, 1'b0, 12'h00F, "s4_left400");
        pix(505, 305, 1'b0, 12'hF00, "s4_at500");
        vfall(1'b1, 2, 600, 300, 12'hF00, 1'b0);
        pix(505, 305, 1'b0, 12'hF00, "s4_swapwr_old");
        pix(605, 305, 1'b0, 12'h00F, "s4_swapwr_notyet");
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(605, 305, 1'b0, 12'hF00, "s4_swapwr_new");
        pix(505, 305, 1'b0, 12'h00F, "s4_swapwr_gone");

        // 5. animation
        wr_spr(0, 200, 200, 12'h000, 1'b1);
        for (int k = 0; k < 35; k++) vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);

        // 6. background, blank, right-edge sprite
        wr_spr(3, 1015, 600, 12'hFF0, 1'b0);
        vfall(1'b0, 0, 0, 0, 12'h000, 1'b0);
        pix(300, 399,  1'b0, 12'h00F, "s6_sky");
        pix(300, 400,  1'b0, 12'h048, "s6_sea");
        pix(210, 205,  1'b1, 12'h000, "s6_blank");
        pix(1020, 605, 1'b0, 12'hFF0, "s6_edge_in");
        pix(1023, 609, 1'b0, 12'hFF0, "s6_edge_last");
        pix(2, 605,    1'b0, 12'h048, "s6_no_wrap");
        pix(1014, 605, 1'b0, 12'h048, "s6_edge_left");
        pix(1019, 610, 1'b0, 12'h048, "s6_edge_below");

        // Mid-frame reset forces p_rgb to 0 on the next edge.
        pix(210, 205, 1'b0, 12'h0F0, "mid_pre");
        pix(210, 205, 1'b0, 12'h0F0, "mid_pre2");
        drain();
        @(negedge vclock);
        reset = 1'b1;
        @(negedge vclock);
        check("mid_reset_p_rgb", {20'd0, p_rgb}, 32'd0);
        check("mid_reset_frame", {24'd0, cur_frame}, 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
